arith_seq_engine: RTL and testbench

- Multi-cycle, handshaked responder for the team's four-mode 4-bit arithmetic function set; it is the request/response counterpart of the combinational arithmetic unit.
- Accepts one operand/mode command per transaction and computes the result with a single shared shift-add multiplier.
- Returns an 8-bit result under valid/ready backpressure.
- Sits behind a command master (sequencer or bus bridge) where area matters more than latency.

---
 rtl/arith_pkg.sv | 36 +++
 rtl/arith_seq_engine_if.sv | 30 +++
 rtl/arith_shift_add_mul.sv | 57 +++++
 rtl/arith_seq_engine.sv | 162 ++++++++++++++++
 tb/tb_arith_seq_engine.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the sequential four-mode arithmetic engine.
package arith_pkg;

    localparam int unsigned ARITH_IN_W     = 4;
    localparam int unsigned ARITH_OUT_W    = 8;
    localparam int unsigned ARITH_MUL_BITS = 5;

    localparam logic [ARITH_IN_W-1:0] E_MASK = 4'b0010;

    typedef enum logic [1:0] {
        MODE_M1 = 2'b00,
        MODE_M2 = 2'b01,
        MODE_M3 = 2'b10,
        MODE_M4 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_COMBINE,
        ST_DONE
    } state_e;

    // Products a mode depends on; bit i selects p(i+1).
    function automatic logic [3:0] mode_mask(input mode_e m);
        logic [3:0] r;
        case (m)
            MODE_M1: r = 4'b0001;
            MODE_M2: r = 4'b0110;
            MODE_M3: r = 4'b1000;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arith_seq_engine_if.sv
// Command/result handshake bundle between a command master and arith_seq_engine.
interface arith_seq_engine_if import arith_pkg::*; #(
    parameter int unsigned IN_W  = ARITH_IN_W,
    parameter int unsigned OUT_W = ARITH_OUT_W
) ();

    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    logic [IN_W-1:0] c;
    logic [IN_W-1:0] d;
    logic [IN_W-1:0] e;
    mode_e           mode;
    logic            out_valid;
    logic            out_ready;
    logic [OUT_W-1:0] y;
    logic            busy;

    modport master (
        output in_valid, a, b, c, d, e, mode, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, b, c, d, e, mode, out_ready,
        output in_ready, out_valid, y, busy
    );

endinterface

// File: rtl/arith_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, product truncated to OUT_W.
module arith_shift_add_mul import arith_pkg::*; #(
    parameter int unsigned OUT_W    = ARITH_OUT_W,
    parameter int unsigned MUL_BITS = ARITH_MUL_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OUT_W-1:0]    mcand,
    input  logic [MUL_BITS-1:0] mplier,
    output logic                done,
    output logic [OUT_W-1:0]    product
);

    localparam int unsigned CNT_W = $clog2(MUL_BITS + 1);

    logic [OUT_W-1:0]    acc;
    logic [OUT_W-1:0]    mc_sh;
    logic [MUL_BITS-1:0] mp_sh;
    logic [CNT_W-1:0]    cnt;
    logic                running;

    // The start cycle performs the first iteration so products can run back to back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            mc_sh   <= '0;
            mp_sh   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= mplier[0] ? mcand : '0;
                mc_sh   <= mcand << 1;
                mp_sh   <= mplier >> 1;
                cnt     <= CNT_W'(1);
                running <= 1'b1;
            end else if (running) begin
                if (mp_sh[0]) begin
                    acc <= acc + mc_sh;
                end
                mc_sh <= mc_sh << 1;
                mp_sh <= mp_sh >> 1;
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(MUL_BITS - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/arith_seq_engine.sv
// Handshaked four-mode arithmetic responder built around one shared shift-add multiplier.
// Define ARITH_SEQ_FAST_EN to compute only the products the selected mode needs.
module arith_seq_engine import arith_pkg::*; #(
    parameter int unsigned IN_W     = ARITH_IN_W,
    parameter int unsigned OUT_W    = ARITH_OUT_W,
    parameter int unsigned MUL_BITS = ARITH_MUL_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    arith_seq_engine_if.slave  bus
);

    state_e              state;
    logic [IN_W-1:0]     a_r, b_r, c_r, d_r, e_r;
    mode_e               mode_r;
    logic [1:0]          sel;
    logic                launch;
    logic [OUT_W-1:0]    prod [4];

    logic [3:0]          accept_mask_c;
    logic [3:0]          run_mask_c;
    logic [2:0]          nxt_c;
    logic [1:0]          lidx_c;
    logic                mul_start_c;
    logic [OUT_W-1:0]    mul_mcand_c;
    logic [MUL_BITS-1:0] mul_mplier_c;
    logic                mul_done;
    logic [OUT_W-1:0]    mul_product;

`ifdef ARITH_SEQ_FAST_EN
    assign accept_mask_c = mode_mask(bus.mode);
    assign run_mask_c    = mode_mask(mode_r);
`else
    assign accept_mask_c = 4'b1111;
    assign run_mask_c    = 4'b1111;
`endif

    // Next needed product after cur; bit 2 set means none remain.
    function automatic logic [2:0] next_prod(input logic [1:0] cur, input logic [3:0] mask);
        logic [2:0] r;
        r = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) r = {1'b0, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic [1:0] first_prod(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign nxt_c       = next_prod(sel, run_mask_c);
    assign lidx_c      = launch ? sel : nxt_c[1:0];
    assign mul_start_c = (state == ST_MUL) && (launch || (mul_done && !nxt_c[2]));

    // Operand pair for the product being launched; operands zero-extended to OUT_W.
    always_comb begin
        mul_mcand_c  = '0;
        mul_mplier_c = '0;
        case (lidx_c)
            2'd0: begin
                mul_mcand_c  = OUT_W'(a_r) + OUT_W'(b_r);
                mul_mplier_c = MUL_BITS'(OUT_W'(c_r) + OUT_W'(d_r));
            end
            2'd1: begin
                mul_mcand_c  = OUT_W'(a_r);
                mul_mplier_c = MUL_BITS'(c_r);
            end
            2'd2: begin
                mul_mcand_c  = OUT_W'(b_r);
                mul_mplier_c = MUL_BITS'(d_r);
            end
            default: begin
                mul_mcand_c  = OUT_W'(a_r ^ b_r) + OUT_W'(d_r);
                mul_mplier_c = MUL_BITS'(e_r & IN_W'(E_MASK));
            end
        endcase
    end

    arith_shift_add_mul #(
        .OUT_W    (OUT_W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_c),
        .mcand   (mul_mcand_c),
        .mplier  (mul_mplier_c),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.y         <= '0;
            a_r           <= '0;
            b_r           <= '0;
            c_r           <= '0;
            d_r           <= '0;
            e_r           <= '0;
            mode_r        <= MODE_M1;
            sel           <= '0;
            launch        <= 1'b0;
            for (int i = 0; i < 4; i++) prod[i] <= '0;
        end else begin
            launch <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_r          <= bus.a;
                        b_r          <= bus.b;
                        c_r          <= bus.c;
                        d_r          <= bus.d;
                        e_r          <= bus.e;
                        mode_r       <= bus.mode;
                        sel          <= first_prod(accept_mask_c);
                        launch       <= 1'b1;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        prod[sel] <= mul_product;
                        if (nxt_c[2]) state <= ST_COMBINE;
                        else          sel   <= nxt_c[1:0];
                    end
                end
                ST_COMBINE: begin
                    case (mode_r)
                        MODE_M1: bus.y <= prod[0];
                        MODE_M2: bus.y <= prod[1] + prod[2];
                        MODE_M3: bus.y <= prod[3];
                        default: bus.y <= (prod[0] + prod[1] + prod[2]) ^ (prod[3] >> 2);
                    endcase
                    bus.out_valid <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_seq_engine.sv
// Self-checking bench for arith_seq_engine: directed vectors, backpressure, mid-op reset, random traffic.
module tb_arith_seq_engine;
    import arith_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    arith_seq_engine_if bus ();

    arith_seq_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions, modulo 256.
    function automatic int ref_y(input int a, input int b, input int c, input int d, input int e, input int m);
        int p1, p2, p3, p4, m1, m2, m3, m4;
        p1 = ((a + b) * (c + d)) % 256;
        p2 = (a * c) % 256;
        p3 = (b * d) % 256;
        p4 = (((a ^ b) + d) * (e & 2)) % 256;
        m1 = p1;
        m2 = (p2 + p3) % 256;
        m3 = p4;
        m4 = ((m1 + m2) % 256) ^ (m3 / 4);
        case (m)
            0: return m1;
            1: return m2;
            2: return m3;
            default: return m4;
        endcase
    endfunction

    function automatic int ref_lat(input int m);
`ifdef ARITH_SEQ_FAST_EN
        int n;
        n = (m == 0 || m == 2) ? 1 : ((m == 1) ? 2 : 4);
        return n * 5 + 2;
`else
        return (m >= 0) ? 22 : 22;
`endif
    endfunction

    task automatic scramble_ops();
        bus.a    = 4'($urandom);
        bus.b    = 4'($urandom);
        bus.c    = 4'($urandom);
        bus.d    = 4'($urandom);
        bus.e    = 4'($urandom);
        bus.mode = mode_e'(2'($urandom));
    endtask

    // One full transaction; optional out_ready hold with a stray in_valid pulse during the hold.
    task automatic run_txn(input int a, input int b, input int c, input int d, input int e,
                           input int m, input int exp_y, input int hold, input int pulse);
        int lat;
        bus.a = 4'(a); bus.b = 4'(b); bus.c = 4'(c); bus.d = 4'(d); bus.e = 4'(e);
        bus.mode = mode_e'(2'(m));
        bus.in_valid = 1'b1;
        check_val("in_ready_idle", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble_ops();
        check_val("busy_after_accept", int'(bus.busy), 1);
        check_val("in_ready_after_accept", int'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, ref_lat(m));
        check_val("y", int'(bus.y), exp_y);
        for (int i = 0; i < hold; i++) begin
            if (pulse != 0 && i == 3) begin
                scramble_ops();
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_val("hold_y", int'(bus.y), exp_y);
            check_val("hold_out_valid", int'(bus.out_valid), 1);
            check_val("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val("release_out_valid", int'(bus.out_valid), 0);
        check_val("release_in_ready", int'(bus.in_ready), 1);
        check_val("release_busy", int'(bus.busy), 0);
    endtask

    initial begin
        int exp1 [4];
        int exp2 [4];
        int seen;
        int ra, rb, rc, rd, re, rm;
        exp1 = '{48, 26, 20, 79};
        exp2 = '{132, 194, 30, 65};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.e = '0;
        bus.mode = MODE_M1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("reset_in_ready", int'(bus.in_ready), 1);
        check_val("reset_out_valid", int'(bus.out_valid), 0);
        check_val("reset_busy", int'(bus.busy), 0);
        check_val("reset_y", int'(bus.y), 0);

        for (int m = 0; m < 4; m++) run_txn(3, 5, 2, 4, 6, m, exp1[m], 0, 0);
        for (int m = 0; m < 4; m++) run_txn(15, 15, 15, 15, 15, m, exp2[m], 0, 0);
        run_txn(3, 5, 2, 4, 5, 2, 0, 0, 0);

        // Backpressure with an ignored command pulse, then a clean follow-up.
        run_txn(3, 5, 2, 4, 6, 3, 79, 10, 1);
        run_txn(3, 5, 2, 4, 6, 0, 48, 0, 0);

        // Reset asserted for the 8th edge after accept abandons the command.
        bus.a = 4'd15; bus.b = 4'd15; bus.c = 4'd15; bus.d = 4'd15; bus.e = 4'd15;
        bus.mode = MODE_M4;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("midrst_in_ready", int'(bus.in_ready), 1);
        check_val("midrst_out_valid", int'(bus.out_valid), 0);
        check_val("midrst_busy", int'(bus.busy), 0);
        check_val("midrst_y", int'(bus.y), 0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        check_val("midrst_no_output", seen, 0);
        run_txn(3, 5, 2, 4, 6, 1, 26, 0, 0);

        for (int t = 0; t < 25; t++) begin
            ra = int'($urandom_range(15));
            rb = int'($urandom_range(15));
            rc = int'($urandom_range(15));
            rd = int'($urandom_range(15));
            re = int'($urandom_range(15));
            rm = int'($urandom_range(3));
            run_txn(ra, rb, rc, rd, re, rm, ref_y(ra, rb, rc, rd, re, rm),
                    int'($urandom_range(4)), int'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
